// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared definitions for the memory bus arbiter.
//   - rd_state_e : read-FSM state encoding
//   - owner_e    : which requester owns or last received a read grant
//   - RD_TYPE_*  : read-type encodings used on the request buses
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        R_IDLE     = 3'd0,
        R_REQ_IF   = 3'd1,
        R_REQ_MEM  = 3'd2,
        R_WAIT_IF  = 3'd3,
        R_WAIT_MEM = 3'd4
    } rd_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    localparam logic [2:0] RD_TYPE_LINE = 3'b100;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: every handshake and data signal of the arbiter.
//   IF read side   : if_rd_req/type/addr, if_rd_rdy, if_ret_valid/last
//   MEM read side  : mem_rd_req/type/addr, mem_rd_rdy, mem_ret_valid/last
//   Shared return  : ret_data
//   MEM write side : mem_wr_req/type/addr/wstrb/data, mem_wr_rdy
//   Downstream     : bus_rd_*, bus_ret_*, bus_wr_*, bus_wr_rdy, bus_wr_done
// Modports:
//   master : the arbiter's view (drives requester handshakes and bus_*_req)
//   slave  : the environment's view (requesters plus downstream bridge)
interface mem_bus_arbiter_if #(
    parameter int unsigned LINE_W = 128
);
    logic              if_rd_req;
    logic [2:0]        if_rd_type;
    logic [31:0]       if_rd_addr;
    logic              if_rd_rdy;
    logic              if_ret_valid;
    logic              if_ret_last;

    logic              mem_rd_req;
    logic [2:0]        mem_rd_type;
    logic [31:0]       mem_rd_addr;
    logic              mem_rd_rdy;
    logic              mem_ret_valid;
    logic              mem_ret_last;

    logic [31:0]       ret_data;

    logic              mem_wr_req;
    logic [2:0]        mem_wr_type;
    logic [31:0]       mem_wr_addr;
    logic [3:0]        mem_wr_wstrb;
    logic [LINE_W-1:0] mem_wr_data;
    logic              mem_wr_rdy;

    logic              bus_rd_req;
    logic [2:0]        bus_rd_type;
    logic [31:0]       bus_rd_addr;
    logic              bus_rd_rdy;
    logic              bus_ret_valid;
    logic              bus_ret_last;
    logic [31:0]       bus_ret_data;

    logic              bus_wr_req;
    logic [2:0]        bus_wr_type;
    logic [31:0]       bus_wr_addr;
    logic [3:0]        bus_wr_wstrb;
    logic [LINE_W-1:0] bus_wr_data;
    logic              bus_wr_rdy;
    logic              bus_wr_done;

    modport master (
        input  if_rd_req, if_rd_type, if_rd_addr,
        output if_rd_rdy, if_ret_valid, if_ret_last,
        input  mem_rd_req, mem_rd_type, mem_rd_addr,
        output mem_rd_rdy, mem_ret_valid, mem_ret_last,
        output ret_data,
        input  mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
        output mem_wr_rdy,
        output bus_rd_req, bus_rd_type, bus_rd_addr,
        input  bus_rd_rdy, bus_ret_valid, bus_ret_last, bus_ret_data,
        output bus_wr_req, bus_wr_type, bus_wr_addr, bus_wr_wstrb, bus_wr_data,
        input  bus_wr_rdy, bus_wr_done
    );

    modport slave (
        output if_rd_req, if_rd_type, if_rd_addr,
        input  if_rd_rdy, if_ret_valid, if_ret_last,
        output mem_rd_req, mem_rd_type, mem_rd_addr,
        input  mem_rd_rdy, mem_ret_valid, mem_ret_last,
        input  ret_data,
        output mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
        input  mem_wr_rdy,
        input  bus_rd_req, bus_rd_type, bus_rd_addr,
        output bus_rd_rdy, bus_ret_valid, bus_ret_last, bus_ret_data,
        input  bus_wr_req, bus_wr_type, bus_wr_addr, bus_wr_wstrb, bus_wr_data,
        output bus_wr_rdy, bus_wr_done
    );

endinterface

// File: rtl/mem_bus_wr_track.sv
// mem_bus_wr_track: tracks the single outstanding downstream write and
// detects a read that targets the same cache line (read-after-write hazard).
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   wr_accept    : a write is accepted downstream this cycle
//   wr_done      : downstream write response pulse
//   wr_line_in   : line address of the write being accepted
//   rd_line      : line address of the MEM read being arbitrated
//   wr_pend      : a write is outstanding
//   wr_line      : line address of the outstanding write
//   wr_free      : a new write may be presented this cycle
//   raw_hit      : rd_line matches the outstanding write's line
module mem_bus_wr_track #(
    parameter int unsigned LINE_BITS = 28
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_accept,
    input  logic                 wr_done,
    input  logic [LINE_BITS-1:0] wr_line_in,
    input  logic [LINE_BITS-1:0] rd_line,
    output logic                 wr_pend,
    output logic [LINE_BITS-1:0] wr_line,
    output logic                 wr_free,
    output logic                 raw_hit
);

    logic                 wr_pend_q, wr_pend_d;
    logic [LINE_BITS-1:0] wr_line_q, wr_line_d;

    always_comb begin
        wr_pend_d = wr_pend_q;
        wr_line_d = wr_line_q;
        // A new accept wins over a same-cycle done: the slot is reused at once.
        if (wr_accept) begin
            wr_pend_d = 1'b1;
            wr_line_d = wr_line_in;
        end else if (wr_done) begin
            wr_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_pend_q <= 1'b0;
            wr_line_q <= '0;
        end else begin
            wr_pend_q <= wr_pend_d;
            wr_line_q <= wr_line_d;
        end
    end

    assign wr_pend = wr_pend_q;
    assign wr_line = wr_line_q;
    // The slot frees in the cycle the response arrives so the next write can overlap it.
    assign wr_free = !wr_pend_q || wr_done;
    // Uses the registered pending flag, so a read matching a write that completes
    // this cycle is still held for one more cycle.
    assign raw_hit = wr_pend_q && (rd_line == wr_line_q);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one downstream cache-line bus between the IF and
// MEM requesters. Reads are serialised (one outstanding), MEM writes pass
// straight through with one outstanding write tracked, and a MEM read that
// hits the line of the in-flight write is held until that write completes.
// Ports:
//   clk     : clock
//   resetn  : synchronous active-low reset
//   bus     : mem_bus_arbiter_if.master carrying all request/return/bus signals
// Parameters:
//   LINE_W  : write-line data width
//   TAG_LSB : lowest address bit of the line-address compare
// Build option:
//   ARB_RR_EN : when defined, round-robin between eligible IF and MEM reads;
//               otherwise MEM has fixed priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned TAG_LSB = 4
) (
    input  logic              clk,
    input  logic              resetn,
    mem_bus_arbiter_if.master bus
);

    localparam int unsigned LineBits = 32 - TAG_LSB;

    rd_state_e   state_q, state_d;
    logic [2:0]  rd_type_q, rd_type_d;
    logic [31:0] rd_addr_q, rd_addr_d;

`ifdef ARB_RR_EN
    owner_e      last_grant_q, last_grant_d;
`endif

    logic                wr_go;
    logic                wr_accept;
    logic                wr_pend;
    logic                wr_free;
    logic                raw_hit;
    logic [LineBits-1:0] wr_line;
    logic [LINE_W-1:0]   wr_data;

    logic mem_ok;
    logic if_ok;
    logic pick_mem;
    logic pick_if;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    mem_bus_wr_track #(
        .LINE_BITS (LineBits)
    ) u_wr_track (
        .clk        (clk),
        .resetn     (resetn),
        .wr_accept  (wr_accept),
        .wr_done    (bus.bus_wr_done),
        .wr_line_in (bus.mem_wr_addr[31:TAG_LSB]),
        .rd_line    (bus.mem_rd_addr[31:TAG_LSB]),
        .wr_pend    (wr_pend),
        .wr_line    (wr_line),
        .wr_free    (wr_free),
        .raw_hit    (raw_hit)
    );

    assign wr_go     = bus.mem_wr_req && wr_free;
    assign wr_accept = wr_go && bus.bus_wr_rdy;
    assign wr_data   = wr_go ? bus.mem_wr_data : '0;

    always_comb begin
        bus.bus_wr_req   = wr_go;
        bus.bus_wr_type  = wr_go ? bus.mem_wr_type  : 3'b000;
        bus.bus_wr_addr  = wr_go ? bus.mem_wr_addr  : 32'h0;
        bus.bus_wr_wstrb = wr_go ? bus.mem_wr_wstrb : 4'h0;
        bus.bus_wr_data  = wr_data;
        bus.mem_wr_rdy   = wr_accept;
    end

    // ------------------------------------------------------------------
    // Read grant
    // ------------------------------------------------------------------
    assign mem_ok = bus.mem_rd_req && !raw_hit;
    assign if_ok  = bus.if_rd_req;

`ifdef ARB_RR_EN
    // On a tie the requester that did not receive the previous grant wins.
    assign pick_mem = mem_ok && (!if_ok || (last_grant_q == OWN_IF));
`else
    assign pick_mem = mem_ok;
`endif
    assign pick_if  = if_ok && !pick_mem;

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rd_type_d = rd_type_q;
        rd_addr_d = rd_addr_q;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            R_IDLE: begin
                if (pick_mem) begin
                    state_d   = R_REQ_MEM;
                    rd_type_d = bus.mem_rd_type;
                    rd_addr_d = bus.mem_rd_addr;
`ifdef ARB_RR_EN
                    last_grant_d = OWN_MEM;
`endif
                end else if (pick_if) begin
                    state_d   = R_REQ_IF;
                    rd_type_d = bus.if_rd_type;
                    rd_addr_d = bus.if_rd_addr;
`ifdef ARB_RR_EN
                    last_grant_d = OWN_IF;
`endif
                end
            end
            R_REQ_IF: begin
                if (bus.bus_rd_rdy) state_d = R_WAIT_IF;
            end
            R_REQ_MEM: begin
                if (bus.bus_rd_rdy) state_d = R_WAIT_MEM;
            end
            R_WAIT_IF, R_WAIT_MEM: begin
                if (bus.bus_ret_valid && bus.bus_ret_last) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= R_IDLE;
            rd_type_q <= 3'b000;
            rd_addr_q <= 32'h0;
`ifdef ARB_RR_EN
            last_grant_q <= OWN_IF;
`endif
        end else begin
            state_q   <= state_d;
            rd_type_q <= rd_type_d;
            rd_addr_q <= rd_addr_d;
`ifdef ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Read outputs: request fields come from flops; returns are passed
    // through combinationally and steered to the owner only.
    // ------------------------------------------------------------------
    always_comb begin
        bus.bus_rd_req    = (state_q == R_REQ_IF) || (state_q == R_REQ_MEM);
        bus.bus_rd_type   = rd_type_q;
        bus.bus_rd_addr   = rd_addr_q;
        bus.if_rd_rdy     = (state_q == R_REQ_IF)  && bus.bus_rd_rdy;
        bus.mem_rd_rdy    = (state_q == R_REQ_MEM) && bus.bus_rd_rdy;
        bus.if_ret_valid  = (state_q == R_WAIT_IF)  && bus.bus_ret_valid;
        bus.if_ret_last   = (state_q == R_WAIT_IF)  && bus.bus_ret_valid && bus.bus_ret_last;
        bus.mem_ret_valid = (state_q == R_WAIT_MEM) && bus.bus_ret_valid;
        bus.mem_ret_last  = (state_q == R_WAIT_MEM) && bus.bus_ret_valid && bus.bus_ret_last;
        bus.ret_data      = ((state_q == R_WAIT_IF) || (state_q == R_WAIT_MEM)) ?
                            bus.bus_ret_data : 32'h0;
    end

    // ------------------------------------------------------------------
    // Requester protocol: a request must stay up until it is accepted.
    // ------------------------------------------------------------------
    a_if_rd_hold : assert property (@(posedge clk) disable iff (!resetn)
        (bus.if_rd_req && !bus.if_rd_rdy) |=> bus.if_rd_req);
    a_mem_rd_hold : assert property (@(posedge clk) disable iff (!resetn)
        (bus.mem_rd_req && !bus.mem_rd_rdy) |=> bus.mem_rd_req);
    a_mem_wr_hold : assert property (@(posedge clk) disable iff (!resetn)
        (bus.mem_wr_req && !bus.mem_wr_rdy) |=> bus.mem_wr_req);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked after
// that settle, well away from the next edge.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    mem_bus_arbiter_if #(.LINE_W(128)) bus ();

    mem_bus_arbiter #(
        .LINE_W  (128),
        .TAG_LSB (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the grant edge (FSM in R_REQ_x). Runs the handshake and
    // four return beats, dropping the served requester's req on acceptance.
    task automatic serve_read(input bit is_mem, input logic [31:0] exp_addr,
                              input logic [2:0] exp_type, input logic [7:0] tag);
        logic [31:0] d;
        check_eq("bus_rd_req", bus.bus_rd_req, 1'b1);
        check_eq("bus_rd_addr", bus.bus_rd_addr, exp_addr);
        check_eq("bus_rd_type", bus.bus_rd_type, exp_type);
        bus.bus_rd_rdy = 1'b1;
        #1;
        check_eq("if_rd_rdy", bus.if_rd_rdy, !is_mem);
        check_eq("mem_rd_rdy", bus.mem_rd_rdy, is_mem);
        tick();
        bus.bus_rd_rdy = 1'b0;
        if (is_mem) bus.mem_rd_req = 1'b0;
        else        bus.if_rd_req  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {tag, 16'h0000, 8'(17 * (i + 1))};
            bus.bus_ret_valid = 1'b1;
            bus.bus_ret_last  = (i == 3);
            bus.bus_ret_data  = d;
            #1;
            check_eq("if_ret_valid", bus.if_ret_valid, !is_mem);
            check_eq("mem_ret_valid", bus.mem_ret_valid, is_mem);
            check_eq("ret_data", bus.ret_data, d);
            check_eq("ret_last", is_mem ? bus.mem_ret_last : bus.if_ret_last, (i == 3));
            tick();
        end
        bus.bus_ret_valid = 1'b0;
        bus.bus_ret_last  = 1'b0;
        bus.bus_ret_data  = 32'h0;
        #1;
        check_eq("state_idle", dut.state_q, R_IDLE);
        check_eq("ret_data_idle", bus.ret_data, 32'h0);
    endtask

    // Presents a line write and has the bridge accept it on this cycle's edge.
    task automatic accept_write(input logic [31:0] addr);
        bus.mem_wr_req   = 1'b1;
        bus.mem_wr_type  = RD_TYPE_LINE;
        bus.mem_wr_addr  = addr;
        bus.mem_wr_wstrb = 4'hF;
        bus.mem_wr_data  = {4{addr}};
        bus.bus_wr_rdy   = 1'b1;
        #1;
        check_eq("bus_wr_req", bus.bus_wr_req, 1'b1);
        check_eq("bus_wr_addr", bus.bus_wr_addr, addr);
        check_eq("bus_wr_data", bus.bus_wr_data, {4{addr}});
        check_eq("mem_wr_rdy", bus.mem_wr_rdy, 1'b1);
        tick();
        bus.mem_wr_req = 1'b0;
        bus.bus_wr_rdy = 1'b0;
        #1;
        check_eq("wr_pend_set", dut.u_wr_track.wr_pend_q, 1'b1);
        check_eq("wr_line", dut.u_wr_track.wr_line_q, {4'h0, addr[31:4]});
        check_eq("bus_wr_req_idle", bus.bus_wr_req, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn = 1'b0;
        bus.if_rd_req = 0;  bus.if_rd_type = 0;  bus.if_rd_addr = 0;
        bus.mem_rd_req = 0; bus.mem_rd_type = 0; bus.mem_rd_addr = 0;
        bus.mem_wr_req = 0; bus.mem_wr_type = 0; bus.mem_wr_addr = 0;
        bus.mem_wr_wstrb = 0; bus.mem_wr_data = 0;
        bus.bus_rd_rdy = 0; bus.bus_ret_valid = 0; bus.bus_ret_last = 0;
        bus.bus_ret_data = 0; bus.bus_wr_rdy = 0; bus.bus_wr_done = 0;

        // Reset state
        tick();
        tick();
        check_eq("rst_state", dut.state_q, R_IDLE);
        check_eq("rst_wr_pend", dut.u_wr_track.wr_pend_q, 1'b0);
        check_eq("rst_bus_rd_req", bus.bus_rd_req, 1'b0);
        check_eq("rst_bus_rd_addr", bus.bus_rd_addr, 32'h0);
        check_eq("rst_bus_wr_req", bus.bus_wr_req, 1'b0);
        check_eq("rst_ret_data", bus.ret_data, 32'h0);
        resetn = 1'b1;
        tick();

        // 1. IF-only line read
        bus.if_rd_req = 1; bus.if_rd_type = RD_TYPE_LINE; bus.if_rd_addr = 32'h1FC0_0000;
        #1;
        check_eq("t1_no_req_yet", bus.bus_rd_req, 1'b0);
        tick();
        check_eq("t1_state", dut.state_q, R_REQ_IF);
        serve_read(1'b0, 32'h1FC0_0000, RD_TYPE_LINE, 8'h00);

        // 2. MEM-only read, then simultaneous IF+MEM with last grant = MEM
        bus.mem_rd_req = 1; bus.mem_rd_type = RD_TYPE_LINE; bus.mem_rd_addr = 32'h0000_3000;
        tick();
        serve_read(1'b1, 32'h0000_3000, RD_TYPE_LINE, 8'h01);
        bus.mem_rd_req = 1; bus.mem_rd_type = RD_TYPE_WORD; bus.mem_rd_addr = 32'h0000_3104;
        bus.if_rd_req = 1;  bus.if_rd_type = RD_TYPE_LINE;  bus.if_rd_addr = 32'h1FC0_0040;
        tick();
`ifdef ARB_RR_EN
        check_eq("t2_first_if", dut.state_q, R_REQ_IF);
        serve_read(1'b0, 32'h1FC0_0040, RD_TYPE_LINE, 8'h02);
        tick();
        serve_read(1'b1, 32'h0000_3104, RD_TYPE_WORD, 8'h03);
`else
        check_eq("t2_first_mem", dut.state_q, R_REQ_MEM);
        serve_read(1'b1, 32'h0000_3104, RD_TYPE_WORD, 8'h02);
        tick();
        serve_read(1'b0, 32'h1FC0_0040, RD_TYPE_LINE, 8'h03);
`endif

        // 3. RAW hold
        accept_write(32'h0000_1230);
        bus.mem_rd_req = 1; bus.mem_rd_type = RD_TYPE_WORD; bus.mem_rd_addr = 32'h0000_123C;
        bus.if_rd_req = 1;  bus.if_rd_type = RD_TYPE_LINE;  bus.if_rd_addr = 32'h1FC0_0010;
        tick();
        check_eq("t3_if_granted", dut.state_q, R_REQ_IF);
        serve_read(1'b0, 32'h1FC0_0010, RD_TYPE_LINE, 8'h04);
        tick();
        check_eq("t3_mem_held", dut.state_q, R_IDLE);
        check_eq("t3_mem_rdy_low", bus.mem_rd_rdy, 1'b0);
        bus.bus_wr_done = 1;
        tick();
        bus.bus_wr_done = 0;
        check_eq("t3_held_on_done", dut.state_q, R_IDLE);
        check_eq("t3_wr_pend_clr", dut.u_wr_track.wr_pend_q, 1'b0);
        tick();
        check_eq("t3_mem_granted", dut.state_q, R_REQ_MEM);
        serve_read(1'b1, 32'h0000_123C, RD_TYPE_WORD, 8'h05);

        // 4. Non-matching MEM read while a write is pending
        accept_write(32'h0000_1230);
        bus.mem_rd_req = 1; bus.mem_rd_type = RD_TYPE_LINE; bus.mem_rd_addr = 32'h0000_2000;
        tick();
        check_eq("t4_mem_granted", dut.state_q, R_REQ_MEM);
        serve_read(1'b1, 32'h0000_2000, RD_TYPE_LINE, 8'h06);

        // 5. Next write waits for done and is accepted in the same cycle
        bus.mem_wr_req = 1; bus.mem_wr_type = RD_TYPE_LINE; bus.mem_wr_addr = 32'h0000_4560;
        bus.mem_wr_wstrb = 4'h3; bus.mem_wr_data = 128'h1;
        bus.bus_wr_rdy = 1;
        #1;
        check_eq("t5_wr_blocked_req", bus.bus_wr_req, 1'b0);
        check_eq("t5_wr_blocked_rdy", bus.mem_wr_rdy, 1'b0);
        tick();
        check_eq("t5_line_old", dut.u_wr_track.wr_line_q, 28'h000_0123);
        bus.bus_wr_done = 1;
        #1;
        check_eq("t5_wr_req_on_done", bus.bus_wr_req, 1'b1);
        check_eq("t5_wstrb", bus.bus_wr_wstrb, 4'h3);
        check_eq("t5_rdy_on_done", bus.mem_wr_rdy, 1'b1);
        tick();
        bus.bus_wr_done = 0; bus.mem_wr_req = 0; bus.bus_wr_rdy = 0;
        check_eq("t5_pend_kept", dut.u_wr_track.wr_pend_q, 1'b1);
        check_eq("t5_line_new", dut.u_wr_track.wr_line_q, 28'h000_0456);
        bus.bus_wr_done = 1;
        tick();
        bus.bus_wr_done = 0;
        check_eq("t5_pend_clr", dut.u_wr_track.wr_pend_q, 1'b0);

        // 6. Reset during R_WAIT_MEM, beat 2 of 4
        accept_write(32'h0000_6000);
        bus.mem_rd_req = 1; bus.mem_rd_type = RD_TYPE_LINE; bus.mem_rd_addr = 32'h0000_5000;
        tick();
        bus.bus_rd_rdy = 1;
        tick();
        bus.bus_rd_rdy = 0; bus.mem_rd_req = 0;
        check_eq("t6_wait_mem", dut.state_q, R_WAIT_MEM);
        bus.bus_ret_valid = 1; bus.bus_ret_data = 32'h0000_0011;
        tick();
        bus.bus_ret_data = 32'h0000_0022;
        resetn = 0;
        tick();
        check_eq("t6_state", dut.state_q, R_IDLE);
        check_eq("t6_mem_ret_valid", bus.mem_ret_valid, 1'b0);
        check_eq("t6_ret_data", bus.ret_data, 32'h0);
        check_eq("t6_bus_rd_addr", bus.bus_rd_addr, 32'h0);
        check_eq("t6_wr_pend", dut.u_wr_track.wr_pend_q, 1'b0);
        bus.bus_ret_valid = 0; bus.bus_ret_data = 0;
        resetn = 1;
        tick();
        bus.if_rd_req = 1; bus.if_rd_type = RD_TYPE_LINE; bus.if_rd_addr = 32'h1FC0_0080;
        tick();
        check_eq("t6_if_granted", dut.state_q, R_REQ_IF);
        serve_read(1'b0, 32'h1FC0_0080, RD_TYPE_LINE, 8'h07);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
